// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI-Lite SRAM slave.
// Response codes, channel states, latency counter.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // 15 base cycles plus up to 7 random ones
    localparam int CNT_W = 5;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rstate_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wstate_t;

    // Unsigned offset compare; addresses below base wrap high
    function automatic logic in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] size
    );
        return (addr - base) < size;
    endfunction

    function automatic cnt_t load_delay(
        input int         lat,
        input logic       rnd,
        input logic [2:0] r
    );
        return cnt_t'(lat) + (rnd ? cnt_t'(r) : cnt_t'(0));
    endfunction

endpackage

// File: rtl/pmem_pkg.sv
// Physical memory behind the pmem access functions shared with the core.
// Sparse word store; words never written read back as zero.
package pmem_pkg;

    logic [31:0] mem [logic [31:0]];
    int unsigned rd_count;
    int unsigned wr_count;
    logic [7:0]  last_wmask;

    function automatic logic [31:0] n_pmem_read(
        input logic [31:0] addr
    );
        rd_count++;
        if (mem.exists(addr))
            return mem[addr];
        return 32'h0;
    endfunction

    function automatic void n_pmem_write(
        input logic [31:0] addr,
        input logic [31:0] data,
        input logic [7:0]  mask
    );
        logic [31:0] w;
        w = mem.exists(addr) ? mem[addr] : 32'h0;
        for (int i = 0; i < 4; i++)
            if (mask[i])
                w[8*i +: 8] = data[8*i +: 8];
        mem[addr]  = w;
        last_wmask = mask;
        wr_count++;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit LFSR, x^8+x^6+x^5+x^4+1.
// Supplies the pseudo-random latency term.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    // Fibonacci shift every cycle, traffic or not
    always_ff @(posedge clk) begin
        if (rst)
            q <= SEED;
        else
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end

endmodule

// File: rtl/axil_sram.sv
// AXI4-Lite slave in front of the simulated physical memory.
// Independent read/write channels with programmable response delay.
module axil_sram
    import axil_pkg::*;
    import pmem_pkg::*;
#(
    parameter logic [31:0] BASE         = 32'h8000_0000,
    parameter logic [31:0] SIZE         = 32'h0800_0000,
    parameter int          RD_LAT       = 1,
    parameter int          WR_LAT       = 1,
    parameter bit          RANDOM_DELAY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    rstate_t     rs;
    cnt_t        rcnt;
    logic [31:0] raddr;

    wstate_t     ws;
    cnt_t        wcnt;
    logic [31:0] waddr;
    logic [31:0] wdat;
    logic [3:0]  wstb;
    logic        aw_held;
    logic        w_held;

    logic [7:0]  lfsr;
    logic        aw_hs;
    logic        w_hs;
    logic        rd_fire;
    logic        wr_fire;
    logic        unused_bits;

    lfsr8 #(
        .SEED (8'hA5)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign arready = (rs == R_IDLE);
    assign rvalid  = (rs == R_RESP);
    assign awready = (ws == W_IDLE) && !aw_held;
    assign wready  = (ws == W_IDLE) && !w_held;
    assign bvalid  = (ws == W_RESP);

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign rd_fire = (rs == R_WAIT) && (rcnt == '0);
    assign wr_fire = (ws == W_WAIT) && (wcnt == '0);

    assign unused_bits = &{1'b0, wstrb[7:4], lfsr[7:3]};

    // Read channel: accept AR, count down, hold R until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            rs    <= R_IDLE;
            rcnt  <= '0;
            raddr <= '0;
        end else begin
            unique case (rs)
                R_IDLE: begin
                    if (arvalid) begin
                        raddr <= araddr;
                        rcnt  <= load_delay(RD_LAT, RANDOM_DELAY, lfsr[2:0]);
                        rs    <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rcnt == '0)
                        rs <= R_RESP;
                    else
                        rcnt <= rcnt - cnt_t'(1);
                end
                R_RESP: begin
                    if (rready)
                        rs <= R_IDLE;
                end
                default: rs <= R_IDLE;
            endcase
        end
    end

    // Write channel: collect AW and W in any order, then commit and respond
    always_ff @(posedge clk) begin
        if (rst) begin
            ws      <= W_IDLE;
            wcnt    <= '0;
            waddr   <= '0;
            wdat    <= '0;
            wstb    <= '0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            unique case (ws)
                W_IDLE: begin
                    if (aw_hs) begin
                        waddr   <= awaddr;
                        aw_held <= 1'b1;
                    end
                    if (w_hs) begin
                        wdat   <= wdata;
                        wstb   <= wstrb[3:0];
                        w_held <= 1'b1;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        wcnt <= load_delay(WR_LAT, RANDOM_DELAY, lfsr[2:0]);
                        ws   <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (wcnt == '0)
                        ws <= W_RESP;
                    else
                        wcnt <= wcnt - cnt_t'(1);
                end
                W_RESP: begin
                    if (bready) begin
                        ws      <= W_IDLE;
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                    end
                end
                default: ws <= W_IDLE;
            endcase
        end
    end

    // Memory commit; read goes first so a same-cycle write is not seen
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
            bresp <= RESP_OKAY;
        end else begin
            if (rd_fire) begin
                if (in_window(raddr, BASE, SIZE)) begin
                    rdata <= n_pmem_read(raddr & ~32'h3);
                    rresp <= RESP_OKAY;
                end else begin
                    rdata <= '0;
                    rresp <= RESP_DECERR;
                end
            end
            if (wr_fire) begin
                if (in_window(waddr, BASE, SIZE)) begin
                    n_pmem_write(waddr & ~32'h3, wdat, {4'b0, wstb});
                    bresp <= RESP_OKAY;
                end else begin
                    bresp <= RESP_DECERR;
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_sram.sv
// Self-checking bench for axil_sram against a sparse-array memory model.
// Randomized traffic plus directed latency, decode and reset scenarios.
`timescale 1ns/1ps
module tb_axil_sram;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] SIZE   = 32'h0800_0000;
    localparam int          RD_LAT = 2;
    localparam int          WR_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] model [logic [31:0]];

    axil_sram #(
        .BASE         (BASE),
        .SIZE         (SIZE),
        .RD_LAT       (RD_LAT),
        .WR_LAT       (WR_LAT),
        .RANDOM_DELAY (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic exp_in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + SIZE);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return exp_in_win(a) ? 2'b00 : 2'b11;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (!exp_in_win(a))
            return 32'h0;
        return model.exists(w) ? model[w] : 32'h0;
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d,
                            input logic [7:0] s);
        logic [31:0] w;
        logic [31:0] v;
        if (exp_in_win(a)) begin
            w = {a[31:2], 2'b00};
            v = model.exists(w) ? model[w] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (s[b]) v[8*b +: 8] = d[8*b +: 8];
            model[w] = v;
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [7:0] s, input int aw_st,
                             input int w_st, output logic [1:0] resp,
                             output int lat);
        bit aw_done;
        bit w_done;
        bit aw_go;
        bit w_go;
        int i;
        int last;
        int n;
        aw_done = 0;
        w_done = 0;
        i = 0;
        n = 0;
        awaddr = a;
        wdata = d;
        wstrb = s;
        while (!(aw_done && w_done) && i < 40) begin
            @(negedge clk);
            awvalid = !aw_done && (i >= aw_st);
            wvalid = !w_done && (i >= w_st);
            aw_go = awvalid && awready;
            w_go = wvalid && wready;
            @(posedge clk);
            #1;
            aw_done = aw_done | aw_go;
            w_done = w_done | w_go;
            i++;
        end
        last = cyc;
        awvalid = 0;
        wvalid = 0;
        if (!(aw_done && w_done)) begin
            tests_run++;
            tests_failed++;
            $display("FAIL aw_w_timeout: aw=%0b w=%0b want 1 1", aw_done, w_done);
        end
        @(negedge clk);
        while (!bvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) begin
            tests_run++;
            tests_failed++;
            $display("FAIL b_timeout: bvalid=%b want 1", bvalid);
        end
        lat = cyc - last;
        resp = bresp;
        bready = 1;
        @(posedge clk);
        #1 bready = 0;
    endtask

    task automatic ar_send(input logic [31:0] a, output int hs);
        int n;
        n = 0;
        @(negedge clk);
        araddr = a;
        arvalid = 1;
        while (!arready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!arready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL ar_timeout: arready=%b want 1", arready);
        end
        @(posedge clk);
        #1 arvalid = 0;
        hs = cyc;
    endtask

    task automatic wait_rvalid(input int hs, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            tests_run++;
            tests_failed++;
            $display("FAIL r_timeout: rvalid=%b want 1", rvalid);
        end
        lat = cyc - hs;
    endtask

    task automatic r_accept();
        rready = 1;
        @(posedge clk);
        #1 rready = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] r, output int lat);
        int hs;
        ar_send(a, hs);
        wait_rvalid(hs, lat);
        d = rdata;
        r = rresp;
        r_accept();
    endtask

    task automatic test_reset();
        logic [7:0] got;
        logic [7:0] want;
        logic [95:0] dat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {arready, awready, wready, rvalid, bvalid, 3'b000};
        want = 8'b1110_0000;
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ar/aw/w/rv/bv=%b want %b", got[7:3], want[7:3]);
        end
        dat = {rdata, 28'h0, rresp, bresp, 32'h0};
        tests_run++;
        if (dat !== 96'h0) begin
            tests_failed++;
            $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b want 0", rdata, rresp, bresp);
        end
        rst = 0;
        @(negedge clk);
        tests_run++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b11100) begin
            tests_failed++;
            $display("FAIL idle_after_reset: %b want 11100", {arready, awready, wready, rvalid, bvalid});
        end
    endtask

    task automatic test_read_latency();
        logic [1:0] r;
        logic [31:0] d;
        int lat;
        axi_write(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 0, r, lat);
        model_wr(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F);
        axi_read(32'h8000_0010, d, r, lat);
        tests_run++;
        if (lat !== 1 + RD_LAT) begin
            tests_failed++;
            $display("FAIL rd_latency: got %0d want %0d", lat, 1 + RD_LAT);
        end
        tests_run++;
        if (d !== 32'hDEAD_BEEF || r !== 2'b00) begin
            tests_failed++;
            $display("FAIL rd_data: got %h/%b want deadbeef/00", d, r);
        end
        axi_read(32'h8000_0013, d, r, lat);
        tests_run++;
        if (d !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL rd_unaligned: got %h want deadbeef", d);
        end
    endtask

    task automatic test_w_first();
        logic [1:0] r;
        logic [31:0] d;
        int lat;
        int unsigned c0;
        axi_write(32'h8000_0020, 32'hAABB_CCDD, 8'h0F, 0, 0, r, lat);
        model_wr(32'h8000_0020, 32'hAABB_CCDD, 8'h0F);
        c0 = pmem_pkg::wr_count;
        axi_write(32'h8000_0020, 32'h1122_3344, 8'h03, 2, 0, r, lat);
        model_wr(32'h8000_0020, 32'h1122_3344, 8'h03);
        tests_run++;
        if (pmem_pkg::wr_count - c0 !== 1) begin
            tests_failed++;
            $display("FAIL wfirst_calls: got %0d want 1", pmem_pkg::wr_count - c0);
        end
        tests_run++;
        if (pmem_pkg::last_wmask !== 8'h03) begin
            tests_failed++;
            $display("FAIL wfirst_mask: got %h want 03", pmem_pkg::last_wmask);
        end
        tests_run++;
        if (lat !== 1 + WR_LAT || r !== 2'b00) begin
            tests_failed++;
            $display("FAIL wfirst_b: lat=%0d resp=%b want %0d/00", lat, r, 1 + WR_LAT);
        end
        axi_read(32'h8000_0020, d, r, lat);
        tests_run++;
        if (d !== 32'hAABB_3344) begin
            tests_failed++;
            $display("FAIL wfirst_readback: got %h want aabb3344", d);
        end
    endtask

    task automatic test_backpressure();
        int hs;
        int lat;
        logic [31:0] d0;
        bit ok;
        ok = 1;
        ar_send(32'h8000_0010, hs);
        wait_rvalid(hs, lat);
        d0 = rdata;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!rvalid || rdata !== d0 || arready !== 1'b0) ok = 0;
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL bp_hold: rvalid=%b rdata=%h arready=%b want 1/%h/0", rvalid, rdata, arready, d0);
        end
        tests_run++;
        if (d0 !== model_rd(32'h8000_0010)) begin
            tests_failed++;
            $display("FAIL bp_data: got %h want %h", d0, model_rd(32'h8000_0010));
        end
        r_accept();
        @(negedge clk);
        tests_run++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: arready=%b rvalid=%b want 1/0", arready, rvalid);
        end
    endtask

    task automatic test_decerr();
        logic [1:0] r;
        logic [31:0] d;
        int lat;
        int unsigned c0;
        logic [31:0] addrs [3];
        addrs[0] = 32'h0000_1000;
        addrs[1] = 32'h8800_0000;
        addrs[2] = 32'h7FFF_FFFC;
        foreach (addrs[i]) begin
            c0 = pmem_pkg::rd_count;
            axi_read(addrs[i], d, r, lat);
            tests_run++;
            if (r !== 2'b11 || d !== 32'h0 || pmem_pkg::rd_count !== c0) begin
                tests_failed++;
                $display("FAIL decerr_rd %h: resp=%b data=%h calls=%0d want 11/0/0", addrs[i], r, d, pmem_pkg::rd_count - c0);
            end
        end
        c0 = pmem_pkg::wr_count;
        axi_write(32'h9000_0000, 32'h5555_AAAA, 8'h0F, 0, 0, r, lat);
        tests_run++;
        if (r !== 2'b11 || pmem_pkg::wr_count !== c0) begin
            tests_failed++;
            $display("FAIL decerr_wr: resp=%b calls=%0d want 11/0", r, pmem_pkg::wr_count - c0);
        end
        axi_write(32'h87FF_FFFC, 32'hCAFE_F00D, 8'h0F, 1, 0, r, lat);
        model_wr(32'h87FF_FFFC, 32'hCAFE_F00D, 8'h0F);
        axi_read(32'h87FF_FFFC, d, r, lat);
        tests_run++;
        if (r !== 2'b00 || d !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL top_word: resp=%b data=%h want 00/cafef00d", r, d);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] r;
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] old;
        int lat;
        int n;
        a = 32'h8000_0040;
        axi_write(a, 32'h0102_0304, 8'h0F, 0, 0, r, lat);
        model_wr(a, 32'h0102_0304, 8'h0F);
        old = model_rd(a);
        @(negedge clk);
        araddr = a;
        arvalid = 1;
        @(posedge clk);
        #1 arvalid = 0;
        @(negedge clk);
        awaddr = a;
        wdata = 32'hF0E0_D0C0;
        wstrb = 8'h0F;
        awvalid = 1;
        wvalid = 1;
        @(posedge clk);
        #1;
        awvalid = 0;
        wvalid = 0;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (rvalid !== 1'b1 || bvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_align: rvalid=%b bvalid=%b want 1 1", rvalid, bvalid);
        end
        tests_run++;
        if (rdata !== old) begin
            tests_failed++;
            $display("FAIL simul_old: got %h want %h", rdata, old);
        end
        rready = 1;
        bready = 1;
        @(posedge clk);
        #1;
        rready = 0;
        bready = 0;
        model_wr(a, 32'hF0E0_D0C0, 8'h0F);
        axi_read(a, d, r, lat);
        tests_run++;
        if (d !== model_rd(a)) begin
            tests_failed++;
            $display("FAIL simul_new: got %h want %h", d, model_rd(a));
        end
    endtask

    task automatic test_reset_mid_write();
        logic [1:0] r;
        logic [31:0] d;
        int lat;
        int unsigned c0;
        c0 = pmem_pkg::wr_count;
        @(negedge clk);
        awaddr = 32'h8000_0010;
        wdata = 32'h0BAD_0BAD;
        wstrb = 8'h0F;
        awvalid = 1;
        wvalid = 1;
        @(posedge clk);
        #1;
        awvalid = 0;
        wvalid = 0;
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        tests_run++;
        if ({bvalid, awready, wready, arready, rvalid} !== 5'b01110) begin
            tests_failed++;
            $display("FAIL rst_mid_ctrl: bv/aw/w/ar/rv=%b want 01110", {bvalid, awready, wready, arready, rvalid});
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (bvalid !== 1'b0 || pmem_pkg::wr_count !== c0) begin
            tests_failed++;
            $display("FAIL rst_mid_drop: bvalid=%b calls=%0d want 0/0", bvalid, pmem_pkg::wr_count - c0);
        end
        axi_read(32'h8000_0010, d, r, lat);
        tests_run++;
        if (d !== model_rd(32'h8000_0010)) begin
            tests_failed++;
            $display("FAIL rst_mid_mem: got %h want %h", d, model_rd(32'h8000_0010));
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] ra;
        logic [31:0] dd;
        logic [31:0] d;
        logic [7:0] s;
        logic [1:0] r;
        int lat;
        int hs;
        int hold;
        int unsigned c0;
        bit ok;
        for (int it = 0; it < 40; it++) begin
            a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = $urandom;
            dd = $urandom;
            s = 8'($urandom_range(0, 255));
            c0 = pmem_pkg::wr_count;
            axi_write(a, dd, s, $urandom_range(0, 3), $urandom_range(0, 3), r, lat);
            model_wr(a, dd, s);
            tests_run++;
            if (r !== exp_resp(a) || lat !== 1 + WR_LAT) begin
                tests_failed++;
                $display("FAIL rnd_b %h: resp=%b lat=%0d want %b/%0d", a, r, lat, exp_resp(a), 1 + WR_LAT);
            end
            tests_run++;
            if (pmem_pkg::wr_count - c0 !== 32'(exp_in_win(a)) ||
                (exp_in_win(a) && pmem_pkg::last_wmask !== {4'b0, s[3:0]})) begin
                tests_failed++;
                $display("FAIL rnd_dpi %h: calls=%0d mask=%h want %0d/%h", a, pmem_pkg::wr_count - c0, pmem_pkg::last_wmask, exp_in_win(a), {4'b0, s[3:0]});
            end
            ra = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ra = $urandom;
            hold = $urandom_range(0, 3);
            ar_send(ra, hs);
            wait_rvalid(hs, lat);
            ok = 1;
            d = rdata;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (rdata !== d || !rvalid || arready) ok = 0;
            end
            tests_run++;
            if (d !== model_rd(ra) || rresp !== exp_resp(ra) || lat !== 1 + RD_LAT || !ok) begin
                tests_failed++;
                $display("FAIL rnd_r %h: data=%h resp=%b lat=%0d hold_ok=%0b want %h/%b/%0d/1", ra, d, rresp, lat, ok, model_rd(ra), exp_resp(ra), 1 + RD_LAT);
            end
            r_accept();
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_w_first();
        test_backpressure();
        test_decerr();
        test_simultaneous();
        test_reset_mid_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
